led_blink_code: RTL and testbench



---
 rtl/led_blink_code.sv | 98 +++++++++
 tb/tb_led_blink_code.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_blink_code.sv
// led_blink_code: repeating blink pattern of N pulses followed by a long gap for a 4-bit status code
module led_blink_code #(
    parameter int PRESCALE = 125000,
    parameter int ON_MS    = 200,
    parameter int OFF_MS   = 300,
    parameter int GAP_MS   = 1500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] code,
    output logic       signal,
    output logic       busy,
    output logic       seq_done
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(PRESCALE - 1);
    localparam logic [11:0]   ON_LAST  = 12'(ON_MS - 1);
    localparam logic [11:0]   OFF_LAST = 12'(OFF_MS - 1);
    localparam logic [11:0]   GAP_LAST = 12'(GAP_MS - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   ms_q, ms_d;
    logic [3:0]    blink_q, blink_d;
    logic [3:0]    code_q, code_d;
    logic          signal_q, signal_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick, expire, enter;
    logic [11:0]   ms_last;

    // State, timers and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            ms_q     <= '0;
            blink_q  <= '0;
            code_q   <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            ms_q     <= ms_d;
            blink_q  <= blink_d;
            code_q   <= code_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next state, code latching and timers; timers restart on every state entry
    always_comb begin
        tick    = presc_q == P_LAST;
        ms_last = (state_q == ON) ? ON_LAST : (state_q == OFF) ? OFF_LAST : GAP_LAST;
        expire  = tick && (ms_q == ms_last);
        state_d = state_q;
        blink_d = blink_q;
        code_d  = code_q;
        case (state_q)
            IDLE: if (code != 4'd0) begin
                state_d = ON;
                code_d  = code;
                blink_d = 4'd0;
            end
            ON: if (expire) begin
                blink_d = blink_q + 4'd1;
                state_d = (blink_d == code_q) ? GAP : OFF;
            end
            OFF: if (expire) state_d = ON;
            GAP: if (expire) begin
                state_d = (code != 4'd0) ? ON : IDLE;
                code_d  = (code != 4'd0) ? code : code_q;
                blink_d = 4'd0;
            end
            default: state_d = IDLE;
        endcase
        enter   = state_d != state_q;
        presc_d = (enter || tick || state_q == IDLE) ? '0 : presc_q + PW'(1);
        ms_d    = (enter || state_q == IDLE) ? '0 : tick ? ms_q + 12'd1 : ms_q;
    end

    // Output values computed from the next state so they change on the transition edge
    always_comb begin
        signal_d = state_d == ON;
        busy_d   = state_d != IDLE;
        done_d   = (state_q == GAP) && expire;
    end

    assign signal   = signal_q;
    assign busy     = busy_q;
    assign seq_done = done_q;
endmodule

// File: tb/tb_led_blink_code.sv
// tb_led_blink_code: directed scenario checks of blink run lengths, gap strobe, code changes and reset
module tb_led_blink_code;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] code  = 4'd0;
    logic       signal, busy, seq_done;
    int total = 0;
    int bad   = 0;

    led_blink_code #(.PRESCALE(4), .ON_MS(2), .OFF_MS(3), .GAP_MS(5)) dut (
        .clock(clock), .reset(reset), .code(code),
        .signal(signal), .busy(busy), .seq_done(seq_done)
    );

    always #5 clock = ~clock;

    // Counts consecutive negedge samples where signal==v, leaving the first differing sample current
    task automatic run_len(input logic v, output int n);
        n = 0;
        while (signal === v && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Counts negedges until seq_done is seen high
    task automatic wait_done(output int n);
        n = 0;
        while (seq_done !== 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
    endtask

    // Reset with code applied, release, and stop at the first sample after release
    task automatic do_reset(input logic [3:0] c);
        @(negedge clock);
        reset = 1'b1;
        code  = c;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset;
        @(negedge clock);
        reset = 1'b1;
        code  = 4'd3;
        repeat (3) @(negedge clock);
        total++; if (signal !== 1'b0) begin bad++; $display("FAIL reset_signal got=%b want=0", signal); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", seq_done); end
    endtask

    task automatic test_code3;
        int n;
        do_reset(4'd3);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL c3_busy got=%b want=1", busy); end
        for (int p = 0; p < 3; p++) begin
            run_len(1'b1, n);
            total++; if (n !== 8) begin bad++; $display("FAIL c3_on%0d got=%0d want=8", p, n); end
            if (p < 2) begin
                run_len(1'b0, n);
                total++; if (n !== 12) begin bad++; $display("FAIL c3_off%0d got=%0d want=12", p, n); end
            end
        end
        wait_done(n);
        total++; if (n !== 20) begin bad++; $display("FAIL c3_gap got=%0d want=20", n); end
        total++; if (signal !== 1'b1) begin bad++; $display("FAIL c3_restart got=%b want=1", signal); end
        run_len(1'b1, n);
        total++; if (n !== 8) begin bad++; $display("FAIL c3_rep_on got=%0d want=8", n); end
        total++; if (seq_done !== 1'b0) begin bad++; $display("FAIL c3_done_width got=%b want=0", seq_done); end
    endtask

    task automatic test_code1;
        int n;
        do_reset(4'd1);
        for (int r = 0; r < 2; r++) begin
            run_len(1'b1, n);
            total++; if (n !== 8) begin bad++; $display("FAIL c1_on%0d got=%0d want=8", r, n); end
            wait_done(n);
            total++; if (n !== 20) begin bad++; $display("FAIL c1_gap%0d got=%0d want=20", r, n); end
        end
    endtask

    task automatic test_change;
        int n;
        do_reset(4'd2);
        run_len(1'b1, n);
        total++; if (n !== 8) begin bad++; $display("FAIL chg_on0 got=%0d want=8", n); end
        code = 4'd5;
        run_len(1'b0, n);
        total++; if (n !== 12) begin bad++; $display("FAIL chg_off0 got=%0d want=12", n); end
        run_len(1'b1, n);
        total++; if (n !== 8) begin bad++; $display("FAIL chg_on1 got=%0d want=8", n); end
        wait_done(n);
        total++; if (n !== 20) begin bad++; $display("FAIL chg_gap got=%0d want=20", n); end
        for (int p = 0; p < 5; p++) begin
            run_len(1'b1, n);
            total++; if (n !== 8) begin bad++; $display("FAIL chg5_on%0d got=%0d want=8", p, n); end
            if (p < 4) begin
                run_len(1'b0, n);
                total++; if (n !== 12) begin bad++; $display("FAIL chg5_off%0d got=%0d want=12", p, n); end
            end
        end
        wait_done(n);
        total++; if (n !== 20) begin bad++; $display("FAIL chg5_gap got=%0d want=20", n); end
    endtask

    task automatic test_drop;
        int n;
        do_reset(4'd4);
        for (int p = 0; p < 4; p++) begin
            if (p == 1) code = 4'd0;
            run_len(1'b1, n);
            total++; if (n !== 8) begin bad++; $display("FAIL drop_on%0d got=%0d want=8", p, n); end
            if (p < 3) begin
                run_len(1'b0, n);
                total++; if (n !== 12) begin bad++; $display("FAIL drop_off%0d got=%0d want=12", p, n); end
            end
        end
        wait_done(n);
        total++; if (n !== 20) begin bad++; $display("FAIL drop_gap got=%0d want=20", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy); end
        run_len(1'b0, n);
        total++; if (n !== 200) begin bad++; $display("FAIL drop_idle_low got=%0d want=200", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_mid_reset;
        int n;
        do_reset(4'd15);
        for (int p = 0; p < 6; p++) begin
            run_len(1'b1, n);
            run_len(1'b0, n);
        end
        total++; if (signal !== 1'b1) begin bad++; $display("FAIL mr_on7 got=%b want=1", signal); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++; if (signal !== 1'b0) begin bad++; $display("FAIL mr_signal got=%b want=0", signal); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy got=%b want=0", busy); end
        reset = 1'b0;
        @(negedge clock);
        total++; if (signal !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mr_restart got=%b%b want=11", signal, busy); end
        run_len(1'b1, n);
        total++; if (n !== 8) begin bad++; $display("FAIL mr_on0 got=%0d want=8", n); end
        for (int p = 1; p < 15; p++) begin
            run_len(1'b0, n);
            total++; if (n !== 12) begin bad++; $display("FAIL mr_off%0d got=%0d want=12", p, n); end
            run_len(1'b1, n);
            total++; if (n !== 8) begin bad++; $display("FAIL mr_on%0d got=%0d want=8", p, n); end
        end
        wait_done(n);
        total++; if (n !== 20) begin bad++; $display("FAIL mr_gap got=%0d want=20", n); end
    endtask

    task automatic test_zero;
        int hits;
        hits = 0;
        @(negedge clock);
        reset = 1'b1;
        code  = 4'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (1000) begin
            @(negedge clock);
            if (signal !== 1'b0 || busy !== 1'b0 || seq_done !== 1'b0) hits++;
        end
        total++; if (hits !== 0) begin bad++; $display("FAIL zero_idle got=%0d active samples want=0", hits); end
    endtask

    initial begin
        test_reset;
        test_code3;
        test_code1;
        test_change;
        test_drop;
        test_mid_reset;
        test_zero;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
